fifo_rr_drain: RTL
==================

Name: fifo_rr_drain

Overview:
Downstream consumer stage for a bank of arbitrated FIFOs. It watches each FIFO's empty flag and head data, and picks one non-empty FIFO per cycle by round-robin. It pops the chosen FIFO and registers the popped word, tagged with its source index, into a single valid/ready output slot. This slot feeds the shared sink.

Parameters:
WIDTH, 8, data width of every FIFO entry and of out_data
NUM_FIFOS, 4, number of upstream FIFOs (>=1)
IDWID, max(1,$clog2(NUM_FIFOS)), width of the source index tag

Ports:
clk  input  1  single clock; all state on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
fifo_empty  input  NUM_FIFOS  per-FIFO empty flag; bit i from FIFO i
fifo_data  input  NUM_FIFOS*WIDTH  per-FIFO head word; slice [i*WIDTH +: WIDTH] from FIFO i
fifo_pop  output  NUM_FIFOS  one-hot-or-zero pop strobe to each FIFO
out_valid  output  1  output slot holds a word
out_ready  input  1  sink accepts word this cycle
out_data  output  WIDTH  registered word
out_id  output  IDWID  index of FIFO the word came from

Behaviour:
- Reset (rst==0, async):
  - out_valid=0, out_data=0, out_id=0
  - priority pointer=0 (FIFO 0 highest)
  - fifo_pop forced to 0 combinationally while rst==0
- Request vector: req = ~fifo_empty.
- Slot free: load_en = !out_valid | out_ready.
- Arbitration (combinational):
  - Round-robin search begins at the priority pointer and wraps modulo NUM_FIFOS.
  - grant = first set req bit in that order; grant is one-hot or zero, and always a subset of req.
- Pop: fifo_pop = grant & {NUM_FIFOS{load_en}}. Never pops an empty FIFO. At most one pop per cycle.
- Capture at posedge, when load_en && |grant:
  - out_data <= fifo_data slice of the granted FIFO
  - out_id <= granted index
  - out_valid <= 1
  - pointer <= (granted index + 1) mod NUM_FIFOS
- Otherwise, if out_ready && out_valid: out_valid <= 0. out_data and out_id hold their values.
- Stall: when out_valid && !out_ready, nothing is popped and the pointer, out_data and out_id are frozen.
- Latency: a head word popped in cycle t is visible on out_data in cycle t+1.
- Throughput: one word per cycle while out_ready=1 and any req is set (back-to-back accept and reload in the same cycle).
- Pointer advances only on an actual capture. Idle cycles and stall cycles leave it unchanged.
- Fairness: with all FIFOs non-empty and out_ready=1, the grant order is 0,1,2,...,N-1,0,... No FIFO waits more than N-1 captures once requesting.
- Wrap: granting index N-1 sets the pointer to 0.
- NUM_FIFOS=1: pointer is constant 0, out_id is constant 0, and the block behaves as a one-entry pipeline register.
- Reset mid-operation: a word held in the slot is discarded, not re-delivered, and the pointer returns to 0. Upstream FIFOs reset on the same rst.
- Arithmetic: the pointer is IDWID bits. The increment wraps explicitly at NUM_FIFOS, not at 2^IDWID, so non-power-of-two counts wrap correctly.

Decomposition:
- Package fifo_arb_pkg:
  - function idwid(n) returning max(1,$clog2(n))
  - localparam defaults for WIDTH and NUM_FIFOS
- Sub-module rr_arbiter:
  - params N and IDWID
  - inputs: req, pointer
  - outputs: grant (one-hot), grant_idx, any_grant
  - purely combinational
- fifo_rr_drain owns the pointer register, the output slot and the pop gating.

Test Plan:
1. Reset, then all empty=1, out_ready=1 for 5 cycles -> fifo_pop=0000, out_valid=0, out_data=0, out_id=0 throughout.
2. NUM_FIFOS=4, all non-empty, heads 0xA0..0xA3, out_ready=1 -> pops 0001,0010,0100,1000,0001; out_id sequence 0,1,2,3,0 one cycle later; out_data tracks the heads.
3. Only FIFO 2 non-empty, pointer=3 -> search wraps 3,0,1,2; fifo_pop=0100; next cycle out_id=2 and pointer=3.
4. Slot loaded with 0x5A/id 1, out_ready=0 for 3 cycles with FIFOs non-empty -> fifo_pop=0000; out_data=0x5A and out_id=1 stable. Raise out_ready -> 0x5A accepted and next FIFO (2) popped that same cycle.
5. Drive rst=0 asynchronously mid-cycle while out_valid=1 -> out_valid drops immediately, fifo_pop=0 while low. After release, first grant goes to FIFO 0.
6. NUM_FIFOS=3, all non-empty -> grant order 0,1,2,0 (pointer never reaches 3); out_id stays within 0..2.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared defaults and the index-width helper for the FIFO drain arbiter.
// No logic, no latency, no backpressure.
package fifo_arb_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_FIFOS = 4;

  // Index width: at least one bit, so a single-FIFO build still has a legal tag
  function automatic int idwid(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant starting at pointer, wrapping modulo N; purely combinational.
// Zero latency; no backpressure, the caller gates the grant.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N     = DEF_NUM_FIFOS,
  parameter int IDWID = idwid(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDWID-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [IDWID-1:0] grant_idx,
  output logic             any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // Wrap at N rather than 2^IDWID so non-power-of-two banks work
      idx = int'(pointer) + k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDWID'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_drain.sv
// Drains a bank of FIFOs round-robin into one registered valid/ready slot tagged with source id.
// One cycle pop-to-output latency; a stalled slot blocks all pops and freezes the pointer.
module fifo_rr_drain
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_FIFOS = DEF_NUM_FIFOS,
  parameter int IDWID     = idwid(NUM_FIFOS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       fifo_empty,
  input  logic [NUM_FIFOS*WIDTH-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]       fifo_pop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [IDWID-1:0]           out_id
);

  logic [NUM_FIFOS-1:0] req;
  logic [NUM_FIFOS-1:0] grant;
  logic [IDWID-1:0]     grant_idx;
  logic                 any_grant;
  logic [IDWID-1:0]     pointer;
  logic [IDWID-1:0]     next_pointer;
  logic                 load_en;
  logic [WIDTH-1:0]     sel_data;

  assign req     = ~fifo_empty;
  assign load_en = !out_valid || out_ready;

  rr_arbiter #(
    .N     (NUM_FIFOS),
    .IDWID (IDWID)
  ) u_arb (
    .req       (req),
    .pointer   (pointer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Pops are suppressed during reset since the upstream FIFOs are resetting too
  assign fifo_pop = rst ? (grant & {NUM_FIFOS{load_en}}) : '0;

  assign next_pointer = (grant_idx == IDWID'(NUM_FIFOS - 1)) ? '0 : grant_idx + IDWID'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (grant[i]) sel_data = sel_data | fifo_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      pointer   <= '0;
    end else if (load_en && any_grant) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_id    <= grant_idx;
      pointer   <= next_pointer;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule
